// File: rtl/parking_entry_frontend_pkg.sv
// Shared definitions for the parking entry front end and the parking system FSM.
package parking_pkg;

  localparam int unsigned PW_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } entry_state_t;

endpackage

// File: rtl/parking_entry_frontend_if.sv
// Gate-side bundle: raw sensors and keypad in, conditioned sensors and password out.
interface parking_entry_if import parking_pkg::*; #(
  parameter int PW_BITS = PW_BITS_DEFAULT
) ();

  logic               front_raw;
  logic               back_raw;
  logic               key_bit;
  logic               key_strobe;
  logic               key_clear;
  logic               frontsensor;
  logic               backsensor;
  logic [PW_BITS-1:0] password;
  logic               password_valid;
  logic               entry_timeout;

  modport master (
    output front_raw, back_raw, key_bit, key_strobe, key_clear,
    input  frontsensor, backsensor, password, password_valid, entry_timeout
  );

  modport slave (
    input  front_raw, back_raw, key_bit, key_strobe, key_clear,
    output frontsensor, backsensor, password, password_valid, entry_timeout
  );

endinterface

// File: rtl/parking_entry_frontend_debounce.sv
// Two-flop synchroniser followed by a filter that needs DEBOUNCE_CYCLES
// consecutive disagreeing samples before the output follows the input.
module parking_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic dout_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive mismatches; any match restarts the run.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (sync2_q != out_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o = out_q;

endmodule

// File: rtl/parking_entry_frontend.sv
// Conditions the gate sensors and assembles the MSB-first keypad password
// for the car currently at the entry.
module parking_entry_frontend import parking_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int PW_BITS         = PW_BITS_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  parking_entry_if.slave bus
);

  localparam int CNT_W = $clog2(PW_BITS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  entry_state_t       state_q, state_d;
  logic [PW_BITS-1:0] pw_q, pw_d, pw_shift_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               front_s, back_s, front_prev_q, back_prev_q;
  logic               front_rise_s, front_fall_s, back_rise_s, last_bit_s;

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front_db (
    .clk(clk), .reset(reset), .din_i(bus.front_raw), .dout_o(front_s)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
    .clk(clk), .reset(reset), .din_i(bus.back_raw), .dout_o(back_s)
  );

  assign front_rise_s = front_s & ~front_prev_q;
  assign front_fall_s = ~front_s & front_prev_q;
  assign back_rise_s  = back_s & ~back_prev_q;
  assign last_bit_s   = (cnt_q == CNT_W'(PW_BITS - 1));
  assign pw_shift_s   = {pw_q[PW_BITS-2:0], bus.key_bit};

  // Entry FSM; inside COLLECT the if-chain order is the same-cycle priority.
  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (front_rise_s) begin
          state_d = COLLECT;
          pw_d    = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (front_fall_s) begin
          state_d = IDLE;
          pw_d    = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end else if (bus.key_clear) begin
          pw_d  = '0;
          cnt_d = '0;
          tmr_d = '0;
        end else if (bus.key_strobe && last_bit_s) begin
          state_d = READY;
          pw_d    = pw_shift_s;
          cnt_d   = '0;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          pw_d      = '0;
          cnt_d     = '0;
          tmr_d     = '0;
          timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          if (bus.key_strobe) begin
            pw_d  = pw_shift_s;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            pw_d = pw_q;
          end
        end
      end
      READY: begin
        if (back_rise_s || front_fall_s) begin
          state_d = IDLE;
          pw_d    = '0;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = IDLE;
        pw_d    = '0;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
    valid_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pw_q         <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      front_prev_q <= 1'b0;
      back_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_q         <= pw_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      front_prev_q <= front_s;
      back_prev_q  <= back_s;
    end
  end

  assign bus.frontsensor    = front_s;
  assign bus.backsensor     = back_s;
  assign bus.password       = pw_q;
  assign bus.password_valid = valid_q;
  assign bus.entry_timeout  = timeout_q;

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Scenario tasks plus a randomized run, each checked against a behavioural model of the gate.
module tb_parking_entry_frontend;

  localparam int PW = 4;
  localparam int DB = 4;
  localparam int TO = 64;
  localparam int S_IDLE = 0, S_COLLECT = 1, S_READY = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parking_entry_if #(.PW_BITS(PW)) bus ();

  parking_entry_frontend #(
    .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .PW_BITS(PW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [PW+3:0] obs;
  assign obs = {bus.frontsensor, bus.backsensor, bus.password_valid, bus.entry_timeout, bus.password};

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: raw/synced sample histories and the entry session.
  int raw_f[$], raw_b[$], syn_f[$], syn_b[$];
  bit m_front, m_back, m_fprev, m_bprev, m_valid, m_to;
  int m_mode, m_pw, m_nbits, m_elapsed;

  function automatic bit settle(input int hist[$], input bit cur);
    if (hist.size() < DB) return 1'b0;
    for (int i = 0; i < DB; i++)
      if (hist[hist.size() - 1 - i] == int'(cur)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [PW+3:0] expv();
    return {m_front, m_back, m_valid, m_to, PW'(m_pw)};
  endfunction

  task automatic model_reset();
    raw_f.delete(); raw_b.delete(); syn_f.delete(); syn_b.delete();
    m_front = 0; m_back = 0; m_fprev = 0; m_bprev = 0; m_valid = 0; m_to = 0;
    m_mode = S_IDLE; m_pw = 0; m_nbits = 0; m_elapsed = 0;
  endtask

  task automatic model_edge();
    bit f_rise, f_fall, b_rise;
    f_rise = m_front && !m_fprev;
    f_fall = !m_front && m_fprev;
    b_rise = m_back && !m_bprev;
    m_to = 0;
    case (m_mode)
      S_IDLE: if (f_rise) begin m_mode = S_COLLECT; m_pw = 0; m_nbits = 0; m_elapsed = 0; end
      S_COLLECT: begin
        if (f_fall) begin
          m_mode = S_IDLE; m_pw = 0; m_nbits = 0; m_elapsed = 0;
        end else if (bus.key_clear) begin
          m_pw = 0; m_nbits = 0; m_elapsed = 0;
        end else if (bus.key_strobe && m_nbits == PW - 1) begin
          m_pw = (m_pw * 2 + int'(bus.key_bit)) % (1 << PW);
          m_mode = S_READY; m_nbits = 0; m_elapsed = 0;
        end else if (m_elapsed == TO - 1) begin
          m_mode = S_IDLE; m_pw = 0; m_nbits = 0; m_elapsed = 0; m_to = 1;
        end else begin
          m_elapsed++;
          if (bus.key_strobe) begin
            m_pw = (m_pw * 2 + int'(bus.key_bit)) % (1 << PW);
            m_nbits++;
          end
        end
      end
      default: if (b_rise || f_fall) begin m_mode = S_IDLE; m_pw = 0; end
    endcase
    m_valid = (m_mode == S_READY);
    m_fprev = m_front;
    m_bprev = m_back;
    raw_f.push_back(int'(bus.front_raw));
    raw_b.push_back(int'(bus.back_raw));
    syn_f.push_back(raw_f.size() >= 3 ? raw_f[raw_f.size() - 3] : 0);
    syn_b.push_back(raw_b.size() >= 3 ? raw_b[raw_b.size() - 3] : 0);
    if (settle(syn_f, m_front)) m_front = !m_front;
    if (settle(syn_b, m_back)) m_back = !m_back;
    if (raw_f.size() > 8) begin void'(raw_f.pop_front()); void'(raw_b.pop_front()); end
    if (syn_f.size() > 8) begin void'(syn_f.pop_front()); void'(syn_b.pop_front()); end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bus.key_bit = b;
    bus.key_strobe = 1'b1;
    step();
    bus.key_strobe = 1'b0;
  endtask

  task automatic go_idle();
    bus.front_raw = 1'b0; bus.back_raw = 1'b0;
    bus.key_strobe = 1'b0; bus.key_clear = 1'b0;
    repeat (10) step();
  endtask

  task automatic enter_collect();
    bus.front_raw = 1'b1;
    repeat (7) step();
  endtask

  task automatic test_reset();
    bus.front_raw = 1'b0; bus.back_raw = 1'b0; bus.key_bit = 1'b0;
    bus.key_strobe = 1'b0; bus.key_clear = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 8'h00); end
    reset = 1'b1;
    model_reset();
    step();
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_debounce();
    int lat;
    for (int p = 0; p < 4; p++) begin
      bus.front_raw = (p % 2 == 0);
      repeat (2) begin
        step();
        n_checks++;
        if (bus.frontsensor !== 1'b0) begin n_fail++; $display("FAIL glitch_filter: got %b expected 0", bus.frontsensor); end
      end
    end
    bus.front_raw = 1'b0;
    repeat (6) step();
    bus.front_raw = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.frontsensor === 1'b1) begin lat = i; break; end
    end
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL debounce_latency: got %0d expected 6", lat); end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL debounce_model: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_normal_entry();
    go_idle();
    enter_collect();
    strobe(1'b0); strobe(1'b1); strobe(1'b0);
    n_checks++;
    if (bus.password_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b expected 0", bus.password_valid); end
    strobe(1'b1);
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b1_0101) begin
      n_fail++; $display("FAIL entry_0101: got %b expected 10101", {bus.password_valid, bus.password});
    end
    bus.back_raw = 1'b1;
    repeat (6) step();
    n_checks++;
    if ({bus.backsensor, bus.password_valid} !== 2'b11) begin
      n_fail++; $display("FAIL back_latency: got %b expected 11", {bus.backsensor, bus.password_valid});
    end
    step();
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b0_0000) begin
      n_fail++; $display("FAIL back_exit: got %b expected 00000", {bus.password_valid, bus.password});
    end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL entry_model: got %h expected %h", obs, expv()); end
    bus.back_raw = 1'b0;
  endtask

  task automatic test_clear();
    go_idle();
    enter_collect();
    strobe(1'b1); strobe(1'b1);
    bus.key_clear = 1'b1; step(); bus.key_clear = 1'b0;
    strobe(1'b0); strobe(1'b1); strobe(1'b0);
    n_checks++;
    if (bus.password_valid !== 1'b0) begin n_fail++; $display("FAIL clear_count: got %b expected 0", bus.password_valid); end
    strobe(1'b1);
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b1_0101) begin
      n_fail++; $display("FAIL clear_then_0101: got %b expected 10101", {bus.password_valid, bus.password});
    end
    go_idle();
    enter_collect();
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    bus.key_clear = 1'b1; bus.key_strobe = 1'b1; bus.key_bit = 1'b1;
    step();
    bus.key_clear = 1'b0; bus.key_strobe = 1'b0;
    strobe(1'b0); strobe(1'b0); strobe(1'b1);
    n_checks++;
    if (bus.password_valid !== 1'b0) begin n_fail++; $display("FAIL clear_beats_strobe: got %b expected 0", bus.password_valid); end
    strobe(1'b1);
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b1_0011) begin
      n_fail++; $display("FAIL clear_strobe_code: got %b expected 10011", {bus.password_valid, bus.password});
    end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL clear_model: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_timeout();
    int k;
    go_idle();
    enter_collect();
    strobe(1'b1); strobe(1'b0);
    k = 2;
    for (int i = 0; i < 100; i++) begin
      step();
      k++;
      if (bus.entry_timeout === 1'b1) break;
    end
    n_checks++;
    if (k != 64) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 64", k); end
    n_checks++;
    if ({bus.entry_timeout, bus.password_valid, bus.password} !== 6'b10_0000) begin
      n_fail++; $display("FAIL timeout_state: got %b expected 100000", {bus.entry_timeout, bus.password_valid, bus.password});
    end
    step();
    n_checks++;
    if (bus.entry_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_width: got %b expected 0", bus.entry_timeout); end
    strobe(1'b1);
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b0_0000) begin
      n_fail++; $display("FAIL idle_ignores_strobe: got %b expected 00000", {bus.password_valid, bus.password});
    end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL timeout_model: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_timeout_race();
    go_idle();
    enter_collect();
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    repeat (60) step();
    strobe(1'b0);
    n_checks++;
    if ({bus.entry_timeout, bus.password_valid, bus.password} !== 6'b01_1010) begin
      n_fail++; $display("FAIL strobe_beats_timeout: got %b expected 011010", {bus.entry_timeout, bus.password_valid, bus.password});
    end
    strobe(1'b1);
    bus.key_clear = 1'b1; step(); bus.key_clear = 1'b0;
    n_checks++;
    if ({bus.entry_timeout, bus.password_valid, bus.password} !== 6'b01_1010) begin
      n_fail++; $display("FAIL ready_frozen: got %b expected 011010", {bus.entry_timeout, bus.password_valid, bus.password});
    end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL race_model: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_abandon();
    bit saw;
    go_idle();
    enter_collect();
    strobe(1'b1); strobe(1'b1);
    bus.front_raw = 1'b0;
    saw = 1'b0;
    repeat (80) begin
      step();
      if (bus.entry_timeout === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL abandon_no_timeout: got %b expected 0", saw); end
    strobe(1'b1);
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b0_0000) begin
      n_fail++; $display("FAIL abandon_idle: got %b expected 00000", {bus.password_valid, bus.password});
    end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL abandon_model: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_reset_mid();
    int lat;
    go_idle();
    enter_collect();
    strobe(1'b1); strobe(1'b0);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected %h", obs, 8'h00); end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.frontsensor === 1'b1) begin lat = i; break; end
    end
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL reset_fresh_rise: got %0d expected 6", lat); end
    step();
    strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b0);
    n_checks++;
    if ({bus.password_valid, bus.password} !== 5'b1_1100) begin
      n_fail++; $display("FAIL post_reset_entry: got %b expected 11100", {bus.password_valid, bus.password});
    end
    n_checks++;
    if (obs !== expv()) begin n_fail++; $display("FAIL reset_model: got %h expected %h", obs, expv()); end
  endtask

  task automatic test_random();
    go_idle();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(24, 0) == 0) bus.front_raw = ~bus.front_raw;
      if ($urandom_range(29, 0) == 0) bus.back_raw = ~bus.back_raw;
      bus.key_strobe = ($urandom_range(2, 0) == 0);
      bus.key_bit    = $urandom_range(1, 0);
      bus.key_clear  = ($urandom_range(39, 0) == 0);
      step();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h expected %h", c, obs, expv());
      end
    end
    bus.key_strobe = 1'b0;
    bus.key_clear = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_debounce();
    test_normal_entry();
    test_clear();
    test_timeout();
    test_timeout_race();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_entry_frontend.md
# parking_entry_frontend

Upstream conditioning stage for the smart car parking controller. It synchronises and debounces the raw front and back vehicle sensors and assembles a serially keyed password. It delivers clean `frontsensor`, `backsensor` and a stable `password` to the parking system FSM. It also asserts `password_valid` once a complete code has been entered for the car at the gate.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed before a debounced sensor output changes (≥2).
- `TIMEOUT_CYCLES`, 64: maximum cycles allowed in COLLECT before the entry is abandoned.
- `PW_BITS`, 4: password width; matches the parking system `password` port.

- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `front_raw`  in  1  raw front sensor, asynchronous to `clk`.
- `back_raw`  in  1  raw back sensor, asynchronous to `clk`.
- `key_bit`  in  1  password bit being entered.
- `key_strobe`  in  1  single-cycle synchronous pulse; samples `key_bit`.
- `key_clear`  in  1  single-cycle synchronous pulse; restarts entry.
- `frontsensor`  out  1  debounced front sensor.
- `backsensor`  out  1  debounced back sensor.
- `password`  out  PW_BITS  assembled code; meaningful only while `password_valid`=1.
- `password_valid`  out  1  complete code held stable.
- `entry_timeout`  out  1  one-cycle pulse when an entry is abandoned for timeout.

## Operation
- Reset (`reset`=0): every output is 0, FSM is IDLE, all counters are 0, and synchroniser flops are 0.
- Sensors: 2-flop synchroniser, then debounce. The debounce counter increments while the synced value differs from the output and clears on any match. The output takes the synced value when the counter reaches `DEBOUNCE_CYCLES`, and the counter clears at that point.
- FSM states: IDLE, COLLECT, READY.
- IDLE:
  - On the `frontsensor` 0→1 edge (registered previous value), go to COLLECT.
  - On that transition, clear `password`, bit count and timer.
  - `key_strobe` and `key_clear` are ignored.
- COLLECT:
  - Timer increments every cycle.
  - `key_strobe`: `password <= {password[PW_BITS-2:0], key_bit}` (MSB first), bit count +1.
  - When the strobe that makes the count `PW_BITS` is registered, go to READY.
  - `key_clear`: clear `password`, count and timer, and stay in COLLECT.
  - Timer reaching `TIMEOUT_CYCLES-1`: go to IDLE, clear `password`, pulse `entry_timeout`.
  - `frontsensor` falling: go to IDLE silently (no timeout pulse).
- READY:
  - `password_valid`=1 and `password` is frozen.
  - On `backsensor` 0→1 edge (car passed) or `frontsensor` falling, go to IDLE, clear `password`, drop valid.
  - `key_strobe` and `key_clear` are ignored.
- Same-cycle priority within COLLECT, highest first:
  1. `frontsensor` fall
  2. `key_clear`
  3. final `key_strobe`
  4. timeout

  A completing strobe on the timeout cycle therefore goes to READY.
- Bit count width is clog2(PW_BITS+1). The timer width is clog2(TIMEOUT_CYCLES). Neither wraps: both are cleared on every state exit.

## Timing
- Sensor latency: a raw edge held stable reaches the debounced output after 2 + `DEBOUNCE_CYCLES` cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` synced cycles never reach the output.
- IDLE→COLLECT happens one cycle after `frontsensor` rises.
- `key_strobe` in cycle n: `password` and count update at the edge ending cycle n.
- After the `PW_BITS`-th strobe in cycle n, `password_valid`=1 from cycle n+1.
- `entry_timeout` is high for exactly one cycle, coincident with the first IDLE cycle.
- `password_valid` falls, and `password` reads 0, in the cycle after the exit condition.
- Asserting reset mid-operation returns everything to reset values asynchronously. The FSM restarts in IDLE, even with `front_raw` held 1, and needs a fresh debounced rise to leave IDLE.

## Structure
- Shared package `parking_pkg`:
  - FSM state enum `entry_state_t` (IDLE, COLLECT, READY).
  - Default `PW_BITS` constant, shared with the parking system.
- Sub-module `parking_debounce`, parameterised by `DEBOUNCE_CYCLES`: synchroniser plus debounce counter, 1-bit in/out. Instantiated twice (front, back).
- FSM, shift register, bit count and timer live in the top module.

## Test plan
- Debounce: `front_raw` toggles 1/0/1 with 2-cycle pulses → `frontsensor` stays 0. Hold 1 → `frontsensor`=1 exactly 6 cycles after the raw edge.
- Normal entry: front rises, then strobes with bits 0,1,0,1 → `password`=4'b0101 and `password_valid`=1 the cycle after the 4th strobe. Then `back_raw` rises → valid drops and `password`=0 after the back debounce latency + 1.
- Clear: strobes 1,1, then `key_clear`, then strobes 0,1,0,1 → `password`=4'b0101 valid. A same-cycle `key_clear`+`key_strobe` leaves count=0.
- Timeout: front rises, 2 strobes, then no key activity → `entry_timeout` pulses once, 64 cycles after COLLECT entry, with FSM IDLE and `password`=0. A 4th strobe on cycle 63 gives READY with no pulse.
- Abandon: in COLLECT, drop `front_raw` → IDLE with no `entry_timeout`. Strobes in IDLE/READY leave `password` unchanged.
- Reset mid-entry: assert `reset`=0 during COLLECT → all outputs 0 immediately. Release with `front_raw`=1 → COLLECT entered only after a debounced rise.
